// File: rtl/reaction_timer_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reaction_timer_ctrl : start/stop control FSM ahead of the reaction-timer BCD
//                       counter chain. Optional macro BEST_TIME_EN keeps the
//                       best (lowest) stop-terminated time.
// Rev 1.0
// ----------------------------------------------------------------------------
module reaction_timer_ctrl #(
    parameter int unsigned MIN_DELAY = 1000,
    parameter int unsigned TIMEOUT   = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        tick,
    input  logic [15:0] bcd_in,
    output logic        cnt_enable,
    output logic        cnt_clear_,
    output logic        led,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        false_start,
    output logic        timeout,
    output logic [15:0] best
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_GO    = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [15:0] C_MIN_DELAY = 16'(MIN_DELAY);
    localparam logic [15:0] C_TIMEOUT   = 16'(TIMEOUT);
    localparam logic [15:0] C_NO_TIME   = 16'h9999;
    localparam logic [9:0]  C_LFSR_SEED = 10'h001;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_start_q;
    logic        r_stop_q;
    logic [9:0]  r_lfsr;
    logic [15:0] r_wait;
    logic [15:0] r_elapsed;

    logic        w_start_rise;
    logic        w_stop_rise;
    logic [15:0] w_elapsed_inc;
    logic [15:0] w_wait_nxt;
    logic [15:0] w_elapsed_nxt;
    logic [15:0] w_result_nxt;
    logic        w_valid_nxt;
    logic        w_fs_nxt;
    logic        w_to_nxt;
    logic        w_led_nxt;
    logic        w_en_nxt;
    logic        w_clr_nxt;

    assign w_start_rise  = start & ~r_start_q;
    assign w_stop_rise   = stop & ~r_stop_q;
    assign w_elapsed_inc = r_elapsed + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait;
        w_elapsed_nxt = r_elapsed;
        w_result_nxt  = result;
        w_valid_nxt   = result_valid;
        w_fs_nxt      = false_start;
        w_to_nxt      = timeout;
        // Lamp/counter controls follow the current state, so they lag the
        // capturing edge by one clock.
        w_led_nxt     = (r_state == S_GO);
        w_en_nxt      = (r_state == S_GO);
        w_clr_nxt     = (r_state == S_GO) || (r_state == S_DONE) || (r_state == S_FAULT);

        case (r_state)
            S_IDLE, S_DONE, S_FAULT: begin
                if (w_start_rise) begin
                    w_state_nxt = S_ARM;
                    w_wait_nxt  = C_MIN_DELAY + {6'd0, r_lfsr};
                    w_valid_nxt = 1'b0;
                    w_fs_nxt    = 1'b0;
                    w_to_nxt    = 1'b0;
                end
            end
            S_ARM: begin
                if (w_stop_rise) begin
                    w_state_nxt = S_FAULT;
                    w_fs_nxt    = 1'b1;
                end else if (tick) begin
                    if (r_wait == 16'd1) begin
                        w_state_nxt   = S_GO;
                        w_elapsed_nxt = 16'd0;
                    end else begin
                        w_wait_nxt = r_wait - 16'd1;
                    end
                end
            end
            S_GO: begin
                if (w_stop_rise) begin
                    w_state_nxt  = S_DONE;
                    w_result_nxt = bcd_in;
                    w_valid_nxt  = 1'b1;
                end else if (tick) begin
                    if (w_elapsed_inc == C_TIMEOUT) begin
                        w_state_nxt  = S_DONE;
                        w_result_nxt = C_NO_TIME;
                        w_to_nxt     = 1'b1;
                        w_valid_nxt  = 1'b1;
                    end else begin
                        w_elapsed_nxt = w_elapsed_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_q    <= 1'b1;
            r_stop_q     <= 1'b1;
            r_lfsr       <= C_LFSR_SEED;
            r_wait       <= 16'd0;
            r_elapsed    <= 16'd0;
            result       <= 16'h0000;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            led          <= 1'b0;
            cnt_enable   <= 1'b0;
            cnt_clear_   <= 1'b0;
        end else begin
            r_start_q    <= start;
            r_stop_q     <= stop;
            r_lfsr       <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
            r_wait       <= w_wait_nxt;
            r_elapsed    <= w_elapsed_nxt;
            result       <= w_result_nxt;
            result_valid <= w_valid_nxt;
            false_start  <= w_fs_nxt;
            timeout      <= w_to_nxt;
            led          <= w_led_nxt;
            cnt_enable   <= w_en_nxt;
            cnt_clear_   <= w_clr_nxt;
        end
    end

`ifdef BEST_TIME_EN
    logic [15:0] r_best;
    logic        w_stop_capture;

    // Packed BCD orders the same as plain binary, so a direct compare works.
    assign w_stop_capture = (r_state == S_GO) && w_stop_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_best <= C_NO_TIME;
        end else if (w_stop_capture && (bcd_in < r_best)) begin
            r_best <= bcd_in;
        end
    end

    assign best = r_best;
`else
    assign best = 16'h0000;
`endif

endmodule
`default_nettype wire
